sp_ram_load_arbiter: RTL and testbench

Front-end stage placed directly upstream of the single-port byte-enabled data/instruction RAM. It arbitrates between the core bus port (req/gnt/rvalid) and a byte-wide preload stream from the boot/SPI loader. Loader bytes are packed little-endian into RAM words and written with byte enables. It drives the RAM's en/addr/wdata/we/be inputs and returns the RAM's synchronous read data to the core.

---
 rtl/sp_ram_load_arbiter_if.sv | 50 +++++
 rtl/sp_ram_load_arbiter.sv | 110 +++++++++++
 tb/tb_sp_ram_load_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_load_arbiter_if.sv
// Bundle of the core bus, loader byte stream and RAM port seen by sp_ram_load_arbiter.
// slave is the arbiter's view; master is the surrounding core/loader/RAM environment.
interface sp_ram_load_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic                  core_req;
    logic                  core_gnt;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic                  core_we;
    logic [LANES-1:0]      core_be;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_rvalid;
    logic [DATA_WIDTH-1:0] core_rdata;

    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic                  load_valid;
    logic                  load_ready;
    logic [7:0]            load_byte;
    logic                  load_last;
    logic                  load_busy;

    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;
    logic [LANES-1:0]      ram_be;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  core_req, core_addr, core_we, core_be, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  load_start, load_addr, load_valid, load_byte, load_last,
        output load_ready, load_busy,
        output ram_en, ram_addr, ram_wdata, ram_we, ram_be,
        input  ram_rdata
    );

    modport master (
        output core_req, core_addr, core_we, core_be, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output load_start, load_addr, load_valid, load_byte, load_last,
        input  load_ready, load_busy,
        input  ram_en, ram_addr, ram_wdata, ram_we, ram_be,
        output ram_rdata
    );
endinterface

// File: rtl/sp_ram_load_arbiter.sv
// Single-port RAM front end: packs loader bytes little-endian into words and
// arbitrates the RAM port between pending loader writes and the core bus.
module sp_ram_load_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    sp_ram_load_arbiter_if.slave bus
);
    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned LW    = $clog2(LANES);
    localparam int unsigned WA    = ADDR_WIDTH - LW;

    logic [WA-1:0]         ptr_q, ptr_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [LANES-1:0]      msk_q, msk_d;
    logic                  pend_q, pend_d;
    logic                  rvalid_q, rvalid_d;

    logic                  gnt;
    logic                  ready;
    logic                  accept;
    logic [LW-1:0]         lane;
    logic                  unused_addr_lsb;

    assign ready  = rst_n & ~pend_q;
    assign gnt    = rst_n & bus.core_req & ~pend_q;
    assign accept = ready & bus.load_valid;
    // A byte arriving with start belongs to lane 0 of the new word.
    assign lane   = bus.load_start ? '0 : cnt_q;

    assign unused_addr_lsb = ^bus.load_addr[LW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            msk_q    <= '0;
            pend_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            msk_q    <= msk_d;
            pend_q   <= pend_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        msk_d    = msk_q;
        pend_d   = pend_q;
        rvalid_d = gnt;

        if (pend_q) begin
            pend_d = 1'b0;
            msk_d  = '0;
            ptr_d  = ptr_q + 1'b1;
        end

        // Start overrides the post-write increment; the pending write still uses the old ptr.
        if (bus.load_start) begin
            ptr_d = bus.load_addr[ADDR_WIDTH-1:LW];
            cnt_d = '0;
            msk_d = '0;
        end

        if (accept) begin
            buf_d[int'(lane)*8 +: 8] = bus.load_byte;
            msk_d[lane]              = 1'b1;
            if (lane == LW'(LANES - 1) || bus.load_last) begin
                pend_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = lane + 1'b1;
            end
        end
    end

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = bus.core_addr;
        bus.ram_wdata = bus.core_wdata;
        bus.ram_be    = bus.core_be;
        if (rst_n && pend_q) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = {ptr_q, {LW{1'b0}}};
            bus.ram_wdata = buf_q;
            bus.ram_be    = msk_q;
        end else if (gnt) begin
            bus.ram_en = 1'b1;
            bus.ram_we = bus.core_we;
        end
    end

    assign bus.core_gnt    = gnt;
    assign bus.core_rvalid = rvalid_q;
    assign bus.core_rdata  = bus.ram_rdata;
    assign bus.load_ready  = ready;
    assign bus.load_busy   = (cnt_q != '0) | pend_q;
endmodule

// File: tb/tb_sp_ram_load_arbiter.sv
// Randomised bench for sp_ram_load_arbiter: loader streams are checked against a
// word-packing model, core traffic against a shadow memory.
module tb_sp_ram_load_arbiter;
    localparam int unsigned AW    = 15;
    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned WORDS = 8192;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    be;
        logic          rdy;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_ram_load_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sp_ram_load_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [WORDS];
    wr_t           wr_log[$];
    wr_t           exp_q[$];
    logic [7:0]    stim[$];

    // Synchronous RAM model; every write it sees is logged for comparison.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_be[b]) mem[bus.ram_addr[AW-1:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
                if (rst_n)
                    wr_log.push_back('{a: bus.ram_addr, d: bus.ram_wdata, be: bus.ram_be,
                                       rdy: bus.load_ready});
            end else begin
                bus.ram_rdata <= mem[bus.ram_addr[AW-1:2]];
            end
        end
    end

    function automatic logic [DW-1:0] be_mask(input logic [3:0] be);
        logic [DW-1:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic fill_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    // Expected loader writes: byte i goes to word i/LANES, lane i%LANES, words consecutive.
    task automatic model_stream(input logic [AW-1:0] base, input bit last_end);
        int n;
        int nw;
        wr_t e;
        n  = stim.size();
        nw = n / LANES + ((last_end && (n % LANES) != 0) ? 1 : 0);
        exp_q.delete();
        for (int k = 0; k < nw; k++) begin
            e.a   = AW'(((int'(base) / LANES + k) % WORDS) * LANES);
            e.d   = '0;
            e.be  = '0;
            e.rdy = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                if (k * LANES + l < n) begin
                    e.d[8*l +: 8] = stim[k*LANES + l];
                    e.be[l]       = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
    endtask

    // Returns just after the edge that accepted the final byte.
    task automatic drive_stream(input logic [AW-1:0] a, input bit do_start,
                                input bit start_with_byte, input bit last_end);
        bit acc;
        if (do_start) begin
            bus.load_start = 1'b1;
            bus.load_addr  = a | AW'($urandom_range(0, 3));
            if (!start_with_byte) begin
                tick();
                bus.load_start = 1'b0;
            end
        end
        for (int i = 0; i < stim.size(); i++) begin
            bus.load_valid = 1'b1;
            bus.load_byte  = stim[i];
            bus.load_last  = last_end && (i == stim.size() - 1);
            acc = 1'b0;
            for (int g = 0; g < 8 && !acc; g++) begin
                @(negedge clk);
                acc = bus.load_ready;
                tick();
                bus.load_start = 1'b0;
            end
            n_tests++;
            if (!acc) begin
                n_fail++;
                $display("FAIL stream_accept byte %0d: ready never seen, required within 8 cycles", i);
            end
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.core_req   = 1'b1;
        bus.load_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_tests += 3;
            if (bus.core_gnt !== 1'b0) begin
                n_fail++; $display("FAIL reset_gnt: got %b, required 0", bus.core_gnt);
            end
            if (bus.ram_en !== 1'b0) begin
                n_fail++; $display("FAIL reset_ram_en: got %b, required 0", bus.ram_en);
            end
            if (bus.load_ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready: got %b, required 0", bus.load_ready);
            end
            tick();
        end
        rst_n          = 1'b1;
        bus.core_req   = 1'b0;
        bus.load_valid = 1'b0;
        @(negedge clk);
        n_tests += 3;
        if (bus.load_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_ready: got %b, required 1", bus.load_ready);
        end
        if (bus.load_busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_busy: got %b, required 0", bus.load_busy);
        end
        if (bus.core_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_rvalid: got %b, required 0", bus.core_rvalid);
        end
        tick();
    endtask

    task automatic test_full_word();
        wr_log.delete();
        fill_stim(8);
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        model_stream(15'h0100, 1'b0);
        drive_stream(15'h0100, 1'b1, 1'($urandom), 1'b0);
        idle(2);
        n_tests++;
        if (wr_log.size() != exp_q.size()) begin
            n_fail++; $display("FAIL full_word_count: got %0d, required %0d", wr_log.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < wr_log.size()) begin
                n_tests++;
                if (wr_log[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL full_word_%0d: got a=%h d=%h be=%h rdy=%b, required a=%h d=%h be=%h rdy=0",
                             k, wr_log[k].a, wr_log[k].d, wr_log[k].be, wr_log[k].rdy,
                             exp_q[k].a, exp_q[k].d, exp_q[k].be);
                end
            end
        end
        n_tests++;
        if (bus.load_busy !== 1'b0) begin
            n_fail++; $display("FAIL full_word_busy: got %b, required 0", bus.load_busy);
        end
    endtask

    task automatic test_last_flush();
        wr_log.delete();
        stim.delete();
        stim.push_back(8'hAA);
        stim.push_back(8'hBB);
        model_stream(15'h0200, 1'b1);
        drive_stream(15'h0200, 1'b1, 1'($urandom), 1'b1);
        idle(2);
        n_tests++;
        if (wr_log.size() != 1) begin
            n_fail++; $display("FAIL last_count: got %0d, required 1", wr_log.size());
        end else begin
            n_tests++;
            if (wr_log[0].a !== 15'h0200 || wr_log[0].be !== 4'h3 || wr_log[0].d[15:0] !== 16'hBBAA) begin
                n_fail++;
                $display("FAIL last_word: got a=%h be=%h d=%h, required a=0200 be=3 d[15:0]=bbaa",
                         wr_log[0].a, wr_log[0].be, wr_log[0].d);
            end
        end
        n_tests++;
        if (bus.load_busy !== 1'b0) begin
            n_fail++; $display("FAIL last_busy: got %b, required 0", bus.load_busy);
        end
    endtask

    task automatic test_core_stall();
        logic [DW-1:0] rv;
        rv = $urandom;
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 15'h0040;
        bus.core_be = 4'hF; bus.core_wdata = rv;
        tick();
        bus.core_req = 1'b0; bus.core_we = 1'b0;
        idle(1);
        fill_stim(4);
        drive_stream(15'h0300, 1'b1, 1'($urandom), 1'b0);
        bus.core_req = 1'b1; bus.core_addr = 15'h0040; bus.core_be = 4'($urandom);
        @(negedge clk);
        n_tests += 2;
        if (bus.core_gnt !== 1'b0) begin
            n_fail++; $display("FAIL stall_gnt_pend: got %b, required 0", bus.core_gnt);
        end
        if (bus.ram_addr !== 15'h0300 || bus.ram_we !== 1'b1) begin
            n_fail++; $display("FAIL stall_loader_cycle: got addr=%h we=%b, required 0300/1",
                               bus.ram_addr, bus.ram_we);
        end
        tick();
        @(negedge clk);
        n_tests += 2;
        if (bus.core_gnt !== 1'b1) begin
            n_fail++; $display("FAIL stall_gnt_next: got %b, required 1", bus.core_gnt);
        end
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 15'h0040) begin
            n_fail++; $display("FAIL stall_core_cycle: got en=%b we=%b addr=%h, required 1/0/0040",
                               bus.ram_en, bus.ram_we, bus.ram_addr);
        end
        tick();
        bus.core_req = 1'b0;
        @(negedge clk);
        n_tests += 2;
        if (bus.core_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL stall_rvalid: got %b, required 1", bus.core_rvalid);
        end
        if (bus.core_rdata !== rv) begin
            n_fail++; $display("FAIL stall_rdata: got %h, required %h", bus.core_rdata, rv);
        end
        tick();
    endtask

    task automatic test_wrap();
        wr_log.delete();
        fill_stim(8);
        model_stream(15'h7FFC, 1'b0);
        drive_stream(15'h7FFC, 1'b1, 1'($urandom), 1'b0);
        idle(2);
        n_tests++;
        if (wr_log.size() != 2 || exp_q.size() != 2) begin
            n_fail++; $display("FAIL wrap_count: got %0d, required 2", wr_log.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (wr_log[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL wrap_word_%0d: got a=%h d=%h be=%h, required a=%h d=%h be=%h",
                             k, wr_log[k].a, wr_log[k].d, wr_log[k].be, exp_q[k].a, exp_q[k].d, exp_q[k].be);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        wr_log.delete();
        fill_stim(3);
        drive_stream(15'h0500, 1'b1, 1'($urandom), 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(2);
        n_tests += 2;
        if (wr_log.size() != 0) begin
            n_fail++; $display("FAIL reset_mid_writes: got %0d, required 0", wr_log.size());
        end
        if (bus.load_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_busy: got %b, required 0", bus.load_busy);
        end
        fill_stim(4);
        model_stream(15'h0000, 1'b0);
        drive_stream(15'h0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        n_tests++;
        if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_mid_next_word: got %0d writes (first a=%h d=%h), required 1 at 0000 d=%h",
                     wr_log.size(), wr_log.size() > 0 ? wr_log[0].a : '0,
                     wr_log.size() > 0 ? wr_log[0].d : '0, exp_q[0].d);
        end
    endtask

    task automatic test_random_streams();
        logic [AW-1:0] a;
        bit            last_end;
        int            n;
        for (int it = 0; it < 6; it++) begin
            wr_log.delete();
            a        = AW'($urandom) & ~AW'(3);
            n        = $urandom_range(1, 11);
            last_end = 1'($urandom);
            fill_stim(n);
            model_stream(a, last_end);
            drive_stream(a, 1'b1, 1'($urandom), last_end);
            idle(2);
            n_tests++;
            if (wr_log.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rand_%0d_count: got %0d, required %0d", it, wr_log.size(), exp_q.size());
            end else begin
                foreach (exp_q[k]) begin
                    n_tests++;
                    if (wr_log[k].a !== exp_q[k].a || wr_log[k].be !== exp_q[k].be ||
                        (wr_log[k].d & be_mask(exp_q[k].be)) !== exp_q[k].d) begin
                        n_fail++;
                        $display("FAIL rand_%0d_word_%0d: got a=%h d=%h be=%h, required a=%h d=%h be=%h",
                                 it, k, wr_log[k].a, wr_log[k].d, wr_log[k].be,
                                 exp_q[k].a, exp_q[k].d, exp_q[k].be);
                    end
                end
            end
            n_tests++;
            if (bus.load_busy !== 1'(!last_end && (n % LANES) != 0)) begin
                n_fail++;
                $display("FAIL rand_%0d_busy: got %b, required %b", it, bus.load_busy,
                         !last_end && (n % LANES) != 0);
            end
        end
    endtask

    task automatic test_core_random();
        logic [DW-1:0] sh[8];
        logic [DW-1:0] prev_exp;
        logic [DW-1:0] m;
        bit            prev_gnt;
        bit            prev_read;
        int            idx;
        prev_gnt  = 1'b0;
        prev_read = 1'b0;
        prev_exp  = '0;
        for (int c = 0; c < 40; c++) begin
            idx             = (c < 8) ? c : $urandom_range(0, 7);
            bus.core_req    = (c < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.core_we     = (c < 8) ? 1'b1 : 1'($urandom);
            bus.core_addr   = AW'(15'h1000 + idx * 4);
            bus.core_be     = (c < 8) ? 4'hF : 4'($urandom);
            bus.core_wdata  = $urandom;
            @(negedge clk);
            n_tests += 2;
            if (bus.core_gnt !== bus.core_req) begin
                n_fail++; $display("FAIL core_gnt_%0d: got %b, required %b", c, bus.core_gnt, bus.core_req);
            end
            if (bus.core_rvalid !== prev_gnt) begin
                n_fail++; $display("FAIL core_rvalid_%0d: got %b, required %b", c, bus.core_rvalid, prev_gnt);
            end
            if (prev_read) begin
                n_tests++;
                if (bus.core_rdata !== prev_exp) begin
                    n_fail++; $display("FAIL core_rdata_%0d: got %h, required %h", c, bus.core_rdata, prev_exp);
                end
            end
            if (bus.core_req) begin
                n_tests++;
                if (bus.ram_en !== 1'b1 || bus.ram_we !== bus.core_we || bus.ram_addr !== bus.core_addr ||
                    bus.ram_be !== bus.core_be || bus.ram_wdata !== bus.core_wdata) begin
                    n_fail++;
                    $display("FAIL core_pass_%0d: got en=%b we=%b addr=%h, required 1/%b/%h",
                             c, bus.ram_en, bus.ram_we, bus.ram_addr, bus.core_we, bus.core_addr);
                end
            end
            prev_gnt  = bus.core_req;
            prev_read = bus.core_req && !bus.core_we;
            prev_exp  = sh[idx];
            if (bus.core_req && bus.core_we) begin
                m       = be_mask(bus.core_be);
                sh[idx] = (sh[idx] & ~m) | (bus.core_wdata & m);
            end
            tick();
        end
        bus.core_req = 1'b0;
        bus.core_we  = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.core_rvalid !== prev_gnt) begin
            n_fail++; $display("FAIL core_rvalid_tail: got %b, required %b", bus.core_rvalid, prev_gnt);
        end
        tick();
    endtask

    initial begin
        bus.core_req   = 1'b0;
        bus.core_addr  = '0;
        bus.core_we    = 1'b0;
        bus.core_be    = '0;
        bus.core_wdata = '0;
        bus.load_start = 1'b0;
        bus.load_addr  = '0;
        bus.load_valid = 1'b0;
        bus.load_byte  = '0;
        bus.load_last  = 1'b0;
        test_reset();
        test_full_word();
        test_last_flush();
        test_core_stall();
        test_wrap();
        test_reset_mid();
        test_random_streams();
        test_core_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
